// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule expander: accepts a 512-bit block, streams W[0..63].
// Optional completed-block counter on blk_cnt when SHA_MSG_SCHED_CNT_EN is defined.
module sha_msg_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last
`ifdef SHA_MSG_SCHED_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [31:0] win_new;
  logic        blk_hs;
  logic        w_hs;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nxt = RUN;
      end
      RUN: begin
        w_valid = 1'b1;
        if (w_ready && (w_idx == 6'd63)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign blk_hs  = blk_valid & blk_ready;
  assign w_hs    = w_valid & w_ready;
  assign w_data  = win[0];
  assign w_last  = w_valid && (w_idx == 6'd63);
  assign win_new = win[0] + ssig0(win[1]) + win[9] + ssig1(win[14]);

  // Sliding 16-word window: win[0] is always the word currently on offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) win[k] <= '0;
      w_idx <= '0;
    end else if (blk_hs) begin
      for (int k = 0; k < 16; k++) win[k] <= blk_data[511 - 32*k -: 32];
      w_idx <= '0;
    end else if (w_hs) begin
      for (int k = 0; k < 15; k++) win[k] <= win[k+1];
      win[15] <= win_new;
      w_idx   <= w_idx + 6'd1;
    end
  end

`ifdef SHA_MSG_SCHED_CNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              blk_cnt_q <= '0;
    else if (w_hs && w_last) blk_cnt_q <= blk_cnt_q + 32'd1;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: "abc" block, backpressure, overlap, mid-run reset,
// all-ones block, and the optional block counter.
module tb_sha_msg_sched;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
`ifdef SHA_MSG_SCHED_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  int           n_cmp;
  int           n_fail;
  logic [31:0]  exp_w [64];
  logic [31:0]  obs_w [64];

  localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] ONES_BLK = {16{32'hFFFFFFFF}};
  localparam logic [511:0] B_BLK    = {8{32'hDEADBEEF, 32'h01234567}};

  sha_msg_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last)
`ifdef SHA_MSG_SCHED_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule from the textbook recurrence over the full W array.
  task automatic build_model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
               + exp_w[i-7]
               + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
               + exp_w[i-16];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offer a block at the current negedge; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [511:0] data);
    int i;
    blk_valid = 1'b1;
    blk_data  = data;
    for (i = 0; i < 200; i++) begin
      if (blk_ready) break;
      @(negedge clk);
    end
    if (i == 200) checkOutput("blk_ready_timeout", 32'(blk_ready), 32'd1);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // Consume words 0..stop_at-1, optionally stalling stall_len cycles at stall_at.
  task automatic drain(input int stall_at, input int stall_len, input int stop_at);
    w_ready = 1'b1;
    for (int t = 0; t < stop_at; t++) begin
      checkOutput($sformatf("w_valid[%0d]", t), 32'(w_valid), 32'd1);
      checkOutput($sformatf("blk_ready_run[%0d]", t), 32'(blk_ready), 32'd0);
      checkOutput($sformatf("w_idx[%0d]", t), 32'(w_idx), t);
      checkOutput($sformatf("w_data[%0d]", t), w_data, exp_w[t]);
      checkOutput($sformatf("w_last[%0d]", t), 32'(w_last), (t == 63) ? 32'd1 : 32'd0);
      obs_w[t] = w_data;
      if (t == stall_at) begin
        w_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          checkOutput("stall_w_data", w_data, exp_w[t]);
          checkOutput("stall_w_idx", 32'(w_idx), t);
          checkOutput("stall_w_valid", 32'(w_valid), 32'd1);
        end
        w_ready = 1'b1;
      end
      @(negedge clk);
    end
    if (stop_at == 64) begin
      checkOutput("post_w_valid", 32'(w_valid), 32'd0);
      checkOutput("post_blk_ready", 32'(blk_ready), 32'd1);
      checkOutput("post_w_last", 32'(w_last), 32'd0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b0;

    #2;
    checkOutput("rst_w_valid", 32'(w_valid), 32'd0);
    checkOutput("rst_blk_ready", 32'(blk_ready), 32'd1);
    checkOutput("rst_w_idx", 32'(w_idx), 32'd0);
    checkOutput("rst_w_data", w_data, 32'd0);
    checkOutput("rst_w_last", 32'(w_last), 32'd0);
`ifdef SHA_MSG_SCHED_CNT_EN
    checkOutput("rst_blk_cnt", blk_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] abc block, continuous w_ready");
    build_model(ABC_BLK);
    applyStimulus(ABC_BLK);
    drain(-1, 0, 64);
    checkOutput("abc_W16", obs_w[16], 32'h61626380);
    checkOutput("abc_W17", obs_w[17], 32'h000F0000);
    checkOutput("abc_W18", obs_w[18], 32'h7DA86405);

    $display("[TB] abc block, 5-cycle stall at w_idx 20");
    applyStimulus(ABC_BLK);
    drain(20, 5, 64);

    $display("[TB] block offered during RUN is held off");
    applyStimulus(ABC_BLK);
    blk_valid = 1'b1;
    blk_data  = B_BLK;
    drain(-1, 0, 64);
    build_model(B_BLK);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = '0;
    checkOutput("overlap_accept_valid", 32'(w_valid), 32'd1);
    drain(-1, 0, 64);

    $display("[TB] reset pulse at w_idx 30");
    build_model(ABC_BLK);
    applyStimulus(ABC_BLK);
    drain(-1, 0, 30);
    checkOutput("pre_rst_w_idx", 32'(w_idx), 32'd30);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_w_valid", 32'(w_valid), 32'd0);
    checkOutput("midrst_w_idx", 32'(w_idx), 32'd0);
    checkOutput("midrst_w_data", w_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_blk_ready", 32'(blk_ready), 32'd1);
    checkOutput("release_w_valid", 32'(w_valid), 32'd0);
    applyStimulus(ABC_BLK);
    drain(-1, 0, 64);

    $display("[TB] all-ones block against model");
    build_model(ONES_BLK);
    applyStimulus(ONES_BLK);
    drain(-1, 0, 64);

`ifdef SHA_MSG_SCHED_CNT_EN
    $display("[TB] block counter");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_model(ABC_BLK);
    repeat (3) begin
      applyStimulus(ABC_BLK);
      drain(-1, 0, 64);
    end
    checkOutput("blk_cnt_three", blk_cnt, 32'd3);
    force dut.blk_cnt_q = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    checkOutput("blk_cnt_preset", blk_cnt, 32'hFFFFFFFF);
    applyStimulus(ABC_BLK);
    drain(-1, 0, 64);
    checkOutput("blk_cnt_wrap", blk_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_msg_sched.md
SHA_MSG_SCHED -- requirements
Module: sha_msg_sched

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port blk_valid  input  1  512-bit message block offered.
REQ-004 SHALL have port blk_ready  output  1  block accepted when blk_valid && blk_ready.
REQ-005 SHALL have port blk_data  input  512  block; W[0] = blk_data[511:480], W[15] = blk_data[31:0].
REQ-006 SHALL have port w_valid  output  1  schedule word W[w_idx] present on w_data.
REQ-007 SHALL have port w_ready  input  1  consumer takes word when w_valid && w_ready.
REQ-008 SHALL have port w_data  output  32  schedule word W[t].
REQ-009 SHALL have port w_idx  output  6  round index t, 0..63.
REQ-010 SHALL have port w_last  output  1  high while w_valid && w_idx == 63.
REQ-011 SHALL have port blk_cnt  output  32  completed-block count; present only with SHA_MSG_SCHED_CNT_EN.

Function
REQ-012 SHALL implement FSM with states IDLE and RUN; IDLE after reset.
REQ-013 SHALL drive blk_ready = 1 in IDLE and 0 in RUN; no block overlap.
REQ-014 SHALL, on block handshake in IDLE, load 16-word window win[0..15] = W[0..15], set w_idx = 0, and enter RUN; w_valid rises the next cycle (1-cycle latency).
REQ-015 SHALL drive w_valid = 1 throughout RUN, w_data = win[0].
REQ-016 SHALL hold w_data, w_idx, w_last and window stable while w_valid && !w_ready.
REQ-017 SHALL, on word handshake, shift win[k] <= win[k+1] for k = 0..14, and win[15] <= win[0] + s0(win[1]) + win[9] + s1(win[14]), all additions mod 2^32.
REQ-018 SHALL use s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x) and s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-019 SHALL increment w_idx on each word handshake; w_idx never wraps inside RUN.
REQ-020 SHALL, on handshake with w_idx == 63, return to IDLE; w_valid = 0 and blk_ready = 1 the following cycle.
REQ-021 SHALL ignore blk_valid and blk_data while in RUN.
REQ-022 SHALL emit exactly 64 words per accepted block, in order W[0]..W[63].
REQ-023 SHALL tolerate w_ready held high continuously: one word per cycle, 64 cycles per block.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force IDLE, w_valid = 0, blk_ready = 1 after release, w_data = 0, w_idx = 0, w_last = 0, window cleared, blk_cnt = 0.
REQ-025 SHALL abandon any partially emitted block on reset mid-RUN; no further words of it are produced.

Configuration
REQ-026 SHALL, with macro SHA_MSG_SCHED_CNT_EN defined, provide blk_cnt incremented by 1 on each handshake with w_last = 1, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL, without SHA_MSG_SCHED_CNT_EN, omit blk_cnt port and counter logic; all other behaviour identical.

Verification
REQ-028 SHALL check "abc" padded block (W[0] = 0x61626380, W[1..14] = 0, W[15] = 0x00000018), w_ready = 1 -> W[16] = 0x61626380, W[17] = 0x000F0000, W[18] = 0x7DA86405, w_last only at w_idx 63.
REQ-029 SHALL check backpressure: w_ready low 5 cycles at w_idx = 20 -> w_data/w_idx unchanged, resulting stream identical to REQ-028 run.
REQ-030 SHALL check blk_valid asserted with new data during RUN -> blk_ready = 0, stream unaffected; new block accepted the cycle after w_idx 63 handshake.
REQ-031 SHALL check rst_n pulsed at w_idx = 30 -> w_valid = 0 immediately, blk_ready = 1 after release, next block restarts at w_idx = 0.
REQ-032 SHALL check all-ones block against software model for all 64 words (mod 2^32 carry wrap).
REQ-033 SHALL check with SHA_MSG_SCHED_CNT_EN: three back-to-back blocks -> blk_cnt = 3; counter preset via force to 0xFFFFFFFF -> wraps to 0.
